f2c_mem_bridge: RTL and testbench
=================================

// Module: f2c_mem_bridge
// PURPOSE
//  Fabric-to-core memory bridge; sits directly downstream of rc's F2C request output.
//  - Consumes rc's F2C requests (remote RD/WR to this core's local memory) and queues them.
//  - Issues them to the core's single-port local memory whenever the core is not using it.
//  - Returns in-order F2C responses (RD_RSP / WR_RSP) into rc's F2C response input.
// PARAMETERS
//  DEPTH   4   request FIFO entries (power of 2, >=2)
//  MEM_AW  12  local memory word-address width (memory = 2^MEM_AW x 32b)
// PORTS
//  QClk                 in   1       core clock
//  RstQnnnL             in   1       asynchronous reset, active-low
//  F2C_ReqValidQ502H    in   1       request from rc valid (no backpressure)
//  F2C_ReqOpcodeQ502H   in   t_opcode  RD or WR
//  F2C_ReqAddressQ502H  in   32      byte address
//  F2C_ReqDataQ502H     in   32      write data (ignored for RD)
//  CoreMemBusy          in   1       core owns memory port this cycle (core has priority)
//  MemReqValid          out  1       memory access this cycle (bridge-owned)
//  MemWrEn              out  1       1=write, 0=read
//  MemAddress           out  MEM_AW  word address = ReqAddress[MEM_AW+1:2]
//  MemWrData            out  32      write data
//  MemRdData            in   32      read data, valid the cycle after a read issue
//  F2C_RspValidQ500H    out  1       response to rc valid (single-cycle pulse per response)
//  F2C_RspOpcodeQ500H   out  t_opcode  RD_RSP or WR_RSP
//  F2C_RspAddressQ500H  out  32      original byte address
//  F2C_RspDataQ500H     out  32      read data (RD), echoed write data (WR)
//  F2C_FifoCount        out  $clog2(DEPTH)+1  current FIFO occupancy
//  F2C_OvfSticky        out  1       request dropped because FIFO was full
//  F2C_BadOpSticky      out  1       request with opcode other than RD/WR dropped
// BEHAVIOUR
//  Reset (RstQnnnL=0, async)
//   - FIFO emptied; in-flight slot cleared.
//   - All outputs 0; opcode outputs = RD_RSP.
//   - Requests in flight at reset produce no response.
//  Enqueue
//   - Valid RD/WR is written at the QClk edge of its valid cycle.
//   - Full and no pop that cycle -> request dropped, F2C_OvfSticky<=1, count unchanged.
//   - Full with a pop in the same cycle -> request accepted, count stays DEPTH.
//   - Any other opcode -> dropped, F2C_BadOpSticky<=1.
//  Issue (combinational from FIFO head)
//   - Condition: FIFO non-empty & !CoreMemBusy.
//   - Drives MemReqValid=1 with WrEn/Address/WrData from the head entry; head pops at the edge.
//   - CoreMemBusy=1 -> MemReqValid=0, FIFO holds, no timeout.
//   - No bypass: a request is never issued in its own arrival cycle.
//  In-flight / response
//   - Issue in cycle T latches {opcode, addr, wrdata} into the in-flight slot.
//   - Cycle T+1: response flops load opcode (RD->RD_RSP, WR->WR_RSP), addr, and data
//     (MemRdData for RD, latched wrdata for WR).
//   - F2C_RspValidQ500H is high in cycle T+2 for exactly one cycle.
//   - Minimum latency: request valid in cycle t0 -> response valid in cycle t0+3.
//   - Throughput: 1 request/cycle; strictly in order; rc always accepts (no rsp stall).
//  Other rules
//   - Pointers wrap modulo DEPTH.
//   - Stickies clear only on reset.
//   - Address bits [31:MEM_AW+2] and [1:0] are ignored for the memory access but returned unmodified.
// STRUCTURE
//  - t_opcode (RD, WR, RD_RSP, WR_RSP) is taken from lotr_pkg.
//  - Add F2C_FIFO_DEPTH and a packed t_f2c_req struct {opcode, addr, data} to lotr_pkg.
//  - Sub-module f2c_req_fifo: DEPTH x t_f2c_req, push/pop/full/empty/count, async active-low reset.
//  - Top level holds the issue logic, the in-flight slot and the response flops.
// TESTING
//  1. RD 0x0000_0010, mem[4]=0xCAFE_F00D, core idle, valid in cycle t0
//     -> in cycle t0+3: RD_RSP, addr 0x10, data 0xCAFEF00D, valid for 1 cycle.
//  2. WR 0x20 data 0x1234_5678, then RD 0x20 on the next cycle
//     -> WR_RSP (data 0x12345678) then RD_RSP (data 0x12345678) on consecutive cycles.
//  3. CoreMemBusy=1 for 6 cycles while RDs to 0x0, 0x4, 0x8 arrive
//     -> MemReqValid=0 throughout, count reaches 3;
//     -> after release, 3 RD_RSPs on 3 consecutive cycles in order.
//  4. CoreMemBusy=1, 5 back-to-back RDs
//     -> 5th dropped, F2C_OvfSticky=1, count=4, exactly 4 responses after release.
//  5. Full FIFO with pop and push in the same cycle
//     -> push accepted, no overflow, all 5 responses returned.
//  6. Request with opcode RD_RSP -> no memory access, no response, F2C_BadOpSticky=1.
//     Reset asserted 1 cycle after a RD issue -> outputs 0 immediately, no response after reset.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared types for the core/fabric request path: opcodes, F2C request payload
// and the default depth of the fabric-to-core request FIFO.
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    localparam int unsigned F2C_FIFO_DEPTH = 4;

    typedef struct packed {
        t_opcode     opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } t_f2c_req;

    function automatic t_opcode f2c_rsp_opcode(input t_opcode op);
        return (op == WR) ? WR_RSP : RD_RSP;
    endfunction

endpackage

// File: rtl/f2c_mem_bridge_if.sv
// Bundle of the F2C request/response buses, the local-memory port and the
// bridge status flags. The bridge uses the slave view, its environment the master view.
interface f2c_mem_bridge_if #(
    parameter int unsigned DEPTH  = lotr_pkg::F2C_FIFO_DEPTH,
    parameter int unsigned MEM_AW = 12
);
    import lotr_pkg::*;

    logic                     F2C_ReqValidQ502H;
    t_opcode                  F2C_ReqOpcodeQ502H;
    logic [31:0]              F2C_ReqAddressQ502H;
    logic [31:0]              F2C_ReqDataQ502H;

    logic                     CoreMemBusy;
    logic                     MemReqValid;
    logic                     MemWrEn;
    logic [MEM_AW-1:0]        MemAddress;
    logic [31:0]              MemWrData;
    logic [31:0]              MemRdData;

    logic                     F2C_RspValidQ500H;
    t_opcode                  F2C_RspOpcodeQ500H;
    logic [31:0]              F2C_RspAddressQ500H;
    logic [31:0]              F2C_RspDataQ500H;

    logic [$clog2(DEPTH):0]   F2C_FifoCount;
    logic                     F2C_OvfSticky;
    logic                     F2C_BadOpSticky;

    modport slave (
        input  F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
        input  CoreMemBusy, MemRdData,
        output MemReqValid, MemWrEn, MemAddress, MemWrData,
        output F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H,
        output F2C_FifoCount, F2C_OvfSticky, F2C_BadOpSticky
    );

    modport master (
        output F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
        output CoreMemBusy, MemRdData,
        input  MemReqValid, MemWrEn, MemAddress, MemWrData,
        input  F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H,
        input  F2C_FifoCount, F2C_OvfSticky, F2C_BadOpSticky
    );

endinterface

// File: rtl/f2c_req_fifo.sv
// DEPTH-entry FIFO of F2C requests. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; a pop on an empty FIFO is ignored.
module f2c_req_fifo import lotr_pkg::*; #(
    parameter int unsigned DEPTH = F2C_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  t_f2c_req               push_data_i,
    input  logic                   pop_i,
    output t_f2c_req               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    t_f2c_req        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/f2c_mem_bridge.sv
// Fabric-to-core memory bridge: queues F2C requests, issues them to the local
// memory whenever the core leaves the port idle and returns in-order responses.
module f2c_mem_bridge import lotr_pkg::*; #(
    parameter int unsigned DEPTH  = F2C_FIFO_DEPTH,
    parameter int unsigned MEM_AW = 12
) (
    input  logic             QClk,
    input  logic             RstQnnnL,
    f2c_mem_bridge_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam t_f2c_req RSP_RESET = '{opcode: RD_RSP, addr: '0, data: '0};

    t_f2c_req        head, push_req;
    logic            fifo_full, fifo_empty, fifo_push, issue, good_op;
    logic [CW-1:0]   fifo_count;

    t_f2c_req        infl_q, infl_d;
    logic            infl_vld_q, infl_vld_d;
    t_f2c_req        rsp_q, rsp_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic            ovf_q, ovf_d;
    logic            badop_q, badop_d;

    assign good_op   = (bus.F2C_ReqOpcodeQ502H == RD) || (bus.F2C_ReqOpcodeQ502H == WR);
    assign issue     = !fifo_empty && !bus.CoreMemBusy;
    assign fifo_push = bus.F2C_ReqValidQ502H && good_op;
    assign push_req  = '{opcode: bus.F2C_ReqOpcodeQ502H,
                         addr:   bus.F2C_ReqAddressQ502H,
                         data:   bus.F2C_ReqDataQ502H};

    f2c_req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
        .clk         (QClk),
        .rst_n       (RstQnnnL),
        .push_i      (fifo_push),
        .push_data_i (push_req),
        .pop_i       (issue),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Memory port is driven straight from the FIFO head and zeroed when idle.
    always_comb begin
        bus.MemReqValid = issue;
        bus.MemWrEn     = 1'b0;
        bus.MemAddress  = '0;
        bus.MemWrData   = '0;
        if (issue) begin
            bus.MemWrEn    = (head.opcode == WR);
            bus.MemAddress = head.addr[MEM_AW+1:2];
            bus.MemWrData  = head.data;
        end
    end

    always_comb begin
        infl_vld_d = issue;
        infl_d     = issue ? head : infl_q;
        rsp_vld_d  = infl_vld_q;
        rsp_d      = rsp_q;
        if (infl_vld_q) begin
            rsp_d.opcode = f2c_rsp_opcode(infl_q.opcode);
            rsp_d.addr   = infl_q.addr;
            rsp_d.data   = (infl_q.opcode == RD) ? bus.MemRdData : infl_q.data;
        end
        ovf_d   = ovf_q   || (fifo_push && fifo_full && !issue);
        badop_d = badop_q || (bus.F2C_ReqValidQ502H && !good_op);
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            infl_vld_q <= 1'b0;
            infl_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_q      <= RSP_RESET;
            ovf_q      <= 1'b0;
            badop_q    <= 1'b0;
        end else begin
            infl_vld_q <= infl_vld_d;
            infl_q     <= infl_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_q      <= rsp_d;
            ovf_q      <= ovf_d;
            badop_q    <= badop_d;
        end
    end

    assign bus.F2C_RspValidQ500H   = rsp_vld_q;
    assign bus.F2C_RspOpcodeQ500H  = rsp_q.opcode;
    assign bus.F2C_RspAddressQ500H = rsp_q.addr;
    assign bus.F2C_RspDataQ500H    = rsp_q.data;
    assign bus.F2C_FifoCount       = fifo_count;
    assign bus.F2C_OvfSticky       = ovf_q;
    assign bus.F2C_BadOpSticky     = badop_q;

endmodule

// File: tb/tb_f2c_mem_bridge.sv
// Bench for f2c_mem_bridge: a behavioural local memory answers the memory port,
// expected responses are queued at stimulus time and compared as responses appear.
module tb_f2c_mem_bridge;
    import lotr_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MEM_AW = 12;
    localparam int unsigned MWORDS = 2 ** MEM_AW;

    logic QClk     = 1'b0;
    logic RstQnnnL = 1'b1;

    f2c_mem_bridge_if #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) bus ();

    f2c_mem_bridge #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) dut (
        .QClk     (QClk),
        .RstQnnnL (RstQnnnL),
        .bus      (bus)
    );

    always #5 QClk = ~QClk;

    typedef struct {
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
        int          exp_cyc;
        bit          b2b;
    } t_exp;

    t_exp        sb [$];
    logic [31:0] mem_arr [MWORDS];
    logic [31:0] ref_mem [MWORDS];
    int          checks       = 0;
    int          failures     = 0;
    int          cyc          = 0;
    int          last_rsp_cyc = -10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge QClk) cyc <= cyc + 1;

    // Behavioural single-port memory: read data appears the cycle after issue.
    always @(posedge QClk) begin
        if (bus.MemReqValid) begin
            if (bus.MemWrEn) mem_arr[bus.MemAddress] <= bus.MemWrData;
            else             bus.MemRdData <= mem_arr[bus.MemAddress];
        end
    end

    always @(negedge QClk) begin
        if (RstQnnnL && bus.F2C_RspValidQ500H) begin
            check("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                t_exp e;
                e = sb.pop_front();
                check("rsp_opcode", 32'(bus.F2C_RspOpcodeQ500H), 32'(e.op));
                check("rsp_addr",   bus.F2C_RspAddressQ500H, e.addr);
                check("rsp_data",   bus.F2C_RspDataQ500H,    e.data);
                if (e.exp_cyc >= 0) check("rsp_latency", 32'(cyc), 32'(e.exp_cyc));
                if (e.b2b)          check("rsp_back_to_back", 32'(cyc), 32'(last_rsp_cyc + 1));
            end
            last_rsp_cyc = cyc;
        end
    end

    function automatic void push_exp(input t_opcode op, input logic [31:0] addr,
                                     input logic [31:0] data, input bit timed, input bit b2b);
        t_exp        e;
        logic [MEM_AW-1:0] w;
        w = addr[MEM_AW+1:2];
        e.addr    = addr;
        e.exp_cyc = timed ? cyc + 3 : -1;
        e.b2b     = b2b;
        if (op == WR) begin
            ref_mem[w] = data;
            e.op       = WR_RSP;
            e.data     = data;
        end else begin
            e.op   = RD_RSP;
            e.data = ref_mem[w];
        end
        sb.push_back(e);
    endfunction

    task automatic drive_req(input t_opcode op, input logic [31:0] addr, input logic [31:0] data);
        bus.F2C_ReqValidQ502H   = 1'b1;
        bus.F2C_ReqOpcodeQ502H  = op;
        bus.F2C_ReqAddressQ502H = addr;
        bus.F2C_ReqDataQ502H    = data;
    endtask

    task automatic send(input t_opcode op, input logic [31:0] addr, input logic [31:0] data,
                        input bit accept, input bit timed, input bit b2b);
        @(posedge QClk); #1;
        drive_req(op, addr, data);
        if (accept) push_exp(op, addr, data, timed, b2b);
    endtask

    task automatic go_idle(input int n);
        repeat (n) begin
            @(posedge QClk); #1;
            bus.F2C_ReqValidQ502H = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge QClk);
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge QClk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req_valid"}, 32'(bus.MemReqValid), 32'd0);
        check({tag, "_rsp_valid"},     32'(bus.F2C_RspValidQ500H), 32'd0);
        check({tag, "_rsp_opcode"},    32'(bus.F2C_RspOpcodeQ500H), 32'(RD_RSP));
        check({tag, "_rsp_addr"},      bus.F2C_RspAddressQ500H, 32'd0);
        check({tag, "_rsp_data"},      bus.F2C_RspDataQ500H, 32'd0);
        check({tag, "_count"},         32'(bus.F2C_FifoCount), 32'd0);
        check({tag, "_ovf"},           32'(bus.F2C_OvfSticky), 32'd0);
        check({tag, "_badop"},         32'(bus.F2C_BadOpSticky), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        RstQnnnL = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge QClk);
        #1;
        RstQnnnL = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < int'(MWORDS); i++) begin
            mem_arr[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[4] = 32'hCAFE_F00D;
        ref_mem[4] = 32'hCAFE_F00D;

        bus.F2C_ReqValidQ502H   = 1'b0;
        bus.F2C_ReqOpcodeQ502H  = RD;
        bus.F2C_ReqAddressQ502H = '0;
        bus.F2C_ReqDataQ502H    = '0;
        bus.CoreMemBusy         = 1'b0;

        #2;
        pulse_reset("reset");

        // Single read: response exactly three cycles after the request.
        send(RD, 32'h0000_0010, 32'h0, 1'b1, 1'b1, 1'b0);
        go_idle(1);
        @(negedge QClk);
        check("t1_mem_req_valid", 32'(bus.MemReqValid), 32'd1);
        check("t1_mem_wr_en",     32'(bus.MemWrEn), 32'd0);
        check("t1_mem_address",   32'(bus.MemAddress), 32'd4);
        wait_drain(20);

        // Write then read-back, plus a read whose unused address bits are set.
        send(WR, 32'h0000_0020, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        send(RD, 32'h0000_0020, 32'h0,         1'b1, 1'b1, 1'b1);
        send(RD, 32'hFFFF_0013, 32'h0,         1'b1, 1'b1, 1'b1);
        go_idle(1);
        wait_drain(20);

        // Core holds the port for six cycles while three reads queue up.
        @(posedge QClk); #1;
        bus.CoreMemBusy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) send(RD, 32'(4 * i), 32'h0, 1'b1, 1'b0, i > 0);
            else       go_idle(1);
            @(negedge QClk);
            check("t3_busy_no_issue", 32'(bus.MemReqValid), 32'd0);
        end
        check("t3_count", 32'(bus.F2C_FifoCount), 32'd3);
        @(posedge QClk); #1;
        bus.CoreMemBusy = 1'b0;
        wait_drain(20);

        // Overflow: fifth request arrives while full and blocked.
        @(posedge QClk); #1;
        bus.CoreMemBusy = 1'b1;
        for (int i = 0; i < 5; i++)
            send(RD, 32'h100 + 32'(4 * i), 32'h0, i < 4, 1'b0, (i > 0) && (i < 4));
        go_idle(1);
        @(negedge QClk);
        check("t4_ovf_sticky", 32'(bus.F2C_OvfSticky), 32'd1);
        check("t4_count",      32'(bus.F2C_FifoCount), 32'd4);
        @(posedge QClk); #1;
        bus.CoreMemBusy = 1'b0;
        wait_drain(20);
        check("t4_ovf_holds", 32'(bus.F2C_OvfSticky), 32'd1);

        // Full FIFO with a pop and a push in the same cycle.
        @(posedge QClk); #1;
        pulse_reset("mid_reset");
        bus.CoreMemBusy = 1'b1;
        for (int i = 0; i < 4; i++)
            send(WR, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, i > 0);
        @(posedge QClk); #1;
        bus.CoreMemBusy = 1'b0;
        drive_req(RD, 32'h0000_0204, 32'h0);
        push_exp(RD, 32'h0000_0204, 32'h0, 1'b0, 1'b1);
        go_idle(1);
        @(negedge QClk);
        check("t5_count_stays_full", 32'(bus.F2C_FifoCount), 32'd4);
        check("t5_no_overflow",      32'(bus.F2C_OvfSticky), 32'd0);
        wait_drain(20);

        // Illegal opcode is dropped without touching memory.
        send(RD_RSP, 32'h0000_0030, 32'h0, 1'b0, 1'b0, 1'b0);
        go_idle(1);
        @(negedge QClk);
        check("t6_badop_no_issue", 32'(bus.MemReqValid), 32'd0);
        check("t6_badop_count",    32'(bus.F2C_FifoCount), 32'd0);
        check("t6_badop_sticky",   32'(bus.F2C_BadOpSticky), 32'd1);
        wait_drain(10);

        // Reset one cycle after an issue kills the pending response.
        send(RD, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0);
        go_idle(1);
        @(negedge QClk);
        check("t6_issue_before_reset", 32'(bus.MemReqValid), 32'd1);
        @(posedge QClk); #1;
        pulse_reset("late_reset");
        for (int i = 0; i < 6; i++) begin
            @(negedge QClk);
            check("t6_no_rsp_after_reset", 32'(bus.F2C_RspValidQ500H), 32'd0);
        end

        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
